nibble_splitter: RTL and testbench
==================================

# nibble_splitter

Byte-to-nibble deconcatenator: accepts 8-bit words on a valid/ready input stream and emits them as two 4-bit nibbles on a valid/ready output stream. It is the receive-side counterpart of our nibble concatenation path, which builds a byte as {upper nibble, lower nibble}. It sits between a byte-wide producer and any 4-bit datapath that consumes fields one at a time. A running completed-byte counter is provided for debug and verification.

## Interface
- HI_FIRST, default 1: 1 = emit in_data[7:4] first, then in_data[3:0]; 0 = lower nibble first.
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  producer has a byte on in_data.
- in_ready  output  1  block accepts the byte this cycle.
- in_data  input  8  byte, laid out as {hi[3:0], lo[3:0]}.
- out_valid  output  1  out_data holds a valid nibble.
- out_ready  input  1  consumer takes the nibble this cycle.
- out_data  output  4  current nibble.
- out_last  output  1  high with the second nibble of a byte.
- byte_count  output  8  count of fully emitted bytes, modulo 256.

## Operation
- One clock, clk. Reset is asynchronous and active-low on rst_n. The block has no other clocks or resets.
- An input handshake occurs when in_valid && in_ready. An output handshake occurs when out_valid && out_ready.
- An 8-bit holding register captures in_data on every input handshake.
- The state machine has three states:
  - EMPTY: out_valid=0, in_ready=1. An input handshake moves to FIRST.
  - FIRST: out_valid=1, out_data = first nibble, out_last=0, in_ready=0. An output handshake moves to SECOND.
  - SECOND: out_valid=1, out_data = second nibble, out_last=1, in_ready=out_ready.
    - Output handshake with a simultaneous input handshake: the new byte is captured and the state moves to FIRST.
    - Output handshake without an input handshake: the state moves to EMPTY.
- With HI_FIRST=1, the first nibble is hold[7:4] and the second is hold[3:0]. With HI_FIRST=0, the order is swapped.
- byte_count increments by 1 on each output handshake in SECOND and wraps from 255 to 0.
- Stall: while out_valid=1 and out_ready=0, out_data, out_last and the state hold unchanged.
- in_data is ignored whenever in_ready=0. The producer must hold the byte until it is accepted.
- out_data is unspecified-but-stable in EMPTY. The implementation keeps the last driven nibble there.

## Timing
- Reset values, asserted immediately on rst_n low and held while it stays low:
  - state = EMPTY
  - out_valid = 0, out_last = 0, out_data = 4'h0
  - hold = 8'h00, byte_count = 8'h00
  - in_ready forced to 0
- Release of rst_n takes effect at the next rising edge. in_ready=1 from the first cycle after release.
- Latency: a byte accepted at edge N presents its first nibble (out_valid=1) in cycle N+1. out_valid is never combinationally dependent on in_valid.
- Throughput with out_ready held high: one byte every 2 cycles, with no bubbles. This relies on the SECOND-state pass-through of in_ready.
- in_ready depends combinationally on out_ready only in SECOND. There is no combinational path from in_valid to any output.
- Reset asserted mid-byte, in FIRST or SECOND: the partial byte is discarded, byte_count is not incremented, and the block returns to EMPTY.

## Test plan
- Reset check: assert rst_n=0 mid-run with random inputs -> out_valid=0, in_ready=0, out_data=0, byte_count=0 asynchronously; after release, in_ready=1 next cycle.
- Single byte, HI_FIRST=1, in_data=8'hA5, out_ready=1 -> out_data 4'hA (out_last=0), then 4'h5 (out_last=1) on consecutive cycles; byte_count=1.
- Single byte, HI_FIRST=0, in_data=8'h3C -> out_data 4'hC then 4'h3; out_last only on 4'h3.
- Back-to-back stream 8'h12, 8'h34, 8'h56, in_valid and out_ready held high -> nibbles 1,2,3,4,5,6 on six consecutive cycles; in_ready high on every SECOND cycle; byte_count=3.
- Backpressure: out_ready=0 for 5 cycles while in FIRST with byte 8'hF0 -> out_data holds 4'hF, in_ready=0, new in_data ignored; after release, 4'hF then 4'h0.
- Wrap: 256 bytes streamed -> byte_count returns to 8'h00. Reset asserted while in SECOND -> byte_count unchanged, state EMPTY.

Source files
------------

// File: rtl/nibble_splitter.sv
// nibble_splitter: takes bytes on a valid/ready input stream and emits each
// one as two 4-bit nibbles on a valid/ready output stream. HI_FIRST selects
// whether the upper or the lower nibble leaves first. byte_count tallies
// fully emitted bytes for debug visibility.
module nibble_splitter #(
   parameter int HI_FIRST = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [3:0] out_data,
   output logic       out_last,
   output logic [7:0] byte_count
);

   typedef enum logic [1:0] {
      EMPTY  = 2'd0,
      FIRST  = 2'd1,
      SECOND = 2'd2
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [7:0] hold;
   logic       run;
   logic [3:0] first_nib;
   logic [3:0] second_nib;
   logic       in_hs;
   logic       last_hs;

   // The nibble order is fixed at elaboration time.
   assign first_nib  = (HI_FIRST != 0) ? hold[7:4] : hold[3:0];
   assign second_nib = (HI_FIRST != 0) ? hold[3:0] : hold[7:4];

   assign in_hs   = in_valid && in_ready;
   assign last_hs = (state == SECOND) && out_ready;

   // run stays low throughout reset and rises on the first edge after
   // release, so in_ready is held low while rst_n is asserted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run <= 1'b0;
      end else begin
         run <= 1'b1;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and output decode. All outputs derive from registers, except
   // in_ready, which passes out_ready through in SECOND so that a new byte
   // can be accepted in the same cycle the previous byte finishes.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      // In EMPTY this keeps showing the last nibble that was driven, which
      // reads 0 after reset because hold is cleared.
      out_data  = second_nib;
      case (state)
         EMPTY: begin
            in_ready = run;
            if (in_valid && run) begin
               state_nxt = FIRST;
            end
         end
         FIRST: begin
            out_valid = 1'b1;
            out_data  = first_nib;
            if (out_ready) begin
               state_nxt = SECOND;
            end
         end
         SECOND: begin
            out_valid = 1'b1;
            out_last  = 1'b1;
            in_ready  = out_ready;
            if (out_ready) begin
               state_nxt = in_valid ? FIRST : EMPTY;
            end
         end
         default: begin
            state_nxt = EMPTY;
         end
      endcase
   end

   // The holding register captures the byte on every accepted input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold <= 8'h00;
      end else if (in_hs) begin
         hold <= in_data;
      end
   end

   // Count bytes whose second nibble has been taken; wraps modulo 256.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_count <= 8'h00;
      end else if (last_hs) begin
         byte_count <= byte_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_nibble_splitter.sv
// Directed bench for nibble_splitter. Two instances, one per nibble order,
// share the same stimulus so every step checks both orderings.
module tb_nibble_splitter;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] in_data;
   logic       out_ready;

   logic       in_ready_h, out_valid_h, out_last_h;
   logic [3:0] out_data_h;
   logic [7:0] byte_count_h;
   logic       in_ready_l, out_valid_l, out_last_l;
   logic [3:0] out_data_l;
   logic [7:0] byte_count_l;

   int checks = 0;
   int errors = 0;

   nibble_splitter #(.HI_FIRST(1)) dut_h (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_h),
      .in_data(in_data), .out_valid(out_valid_h), .out_ready(out_ready),
      .out_data(out_data_h), .out_last(out_last_h), .byte_count(byte_count_h)
   );

   nibble_splitter #(.HI_FIRST(0)) dut_l (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_l),
      .in_data(in_data), .out_valid(out_valid_l), .out_ready(out_ready),
      .out_data(out_data_l), .out_last(out_last_l), .byte_count(byte_count_l)
   );

   // 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to 1 ns after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Check both instances' output stream. second selects which nibble of b is
   // expected from the hi-first instance; the lo-first one shows the other.
   task automatic chk_out(input string tag, input logic v, input logic l,
                          input logic [7:0] b, input bit second);
      logic [3:0] eh;
      logic [3:0] el;
      eh = second ? b[3:0] : b[7:4];
      el = second ? b[7:4] : b[3:0];
      chk({tag, "_valid_h"}, {7'd0, out_valid_h}, {7'd0, v});
      chk({tag, "_valid_l"}, {7'd0, out_valid_l}, {7'd0, v});
      chk({tag, "_last_h"},  {7'd0, out_last_h},  {7'd0, l});
      chk({tag, "_last_l"},  {7'd0, out_last_l},  {7'd0, l});
      chk({tag, "_data_h"},  {4'd0, out_data_h},  {4'd0, eh});
      chk({tag, "_data_l"},  {4'd0, out_data_l},  {4'd0, el});
   endtask

   task automatic chk_rdy(input string tag, input logic r);
      chk({tag, "_rdy_h"}, {7'd0, in_ready_h}, {7'd0, r});
      chk({tag, "_rdy_l"}, {7'd0, in_ready_l}, {7'd0, r});
   endtask

   task automatic chk_cnt(input string tag, input logic [7:0] c);
      chk({tag, "_cnt_h"}, byte_count_h, c);
      chk({tag, "_cnt_l"}, byte_count_l, c);
   endtask

   task automatic chk_reset(input string tag);
      chk_rdy(tag, 1'b0);
      chk({tag, "_valid_h"}, {7'd0, out_valid_h}, 8'h00);
      chk({tag, "_valid_l"}, {7'd0, out_valid_l}, 8'h00);
      chk({tag, "_last_h"},  {7'd0, out_last_h},  8'h00);
      chk({tag, "_data_h"},  {4'd0, out_data_h},  8'h00);
      chk({tag, "_data_l"},  {4'd0, out_data_l},  8'h00);
      chk_cnt(tag, 8'h00);
   endtask

   logic [7:0] stream [3];

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b0;
      stream[0] = 8'h12;
      stream[1] = 8'h34;
      stream[2] = 8'h56;

      // Reset state, including while inputs are active.
      #1;
      chk_reset("rst0");
      in_valid  = 1'b1;
      in_data   = 8'hEE;
      out_ready = 1'b1;
      tick();
      chk_reset("rst1");
      tick();
      in_valid = 1'b0;
      #2 rst_n = 1'b1;
      tick();
      chk_rdy("rel", 1'b1);
      chk_out("rel", 1'b0, 1'b0, 8'h00, 1'b1);

      // Single byte A5 with out_ready high.
      in_valid = 1'b1;
      in_data  = 8'hA5;
      out_ready = 1'b1;
      #1;
      chk_rdy("a5_empty", 1'b1);
      tick();
      in_valid = 1'b0;
      #1;
      chk_out("a5_first", 1'b1, 1'b0, 8'hA5, 1'b0);
      chk_rdy("a5_first", 1'b0);
      tick();
      chk_out("a5_second", 1'b1, 1'b1, 8'hA5, 1'b1);
      chk_rdy("a5_second", 1'b1);
      tick();
      chk_out("a5_done", 1'b0, 1'b0, 8'hA5, 1'b1);
      chk_cnt("a5_done", 8'd1);

      // Single byte 3C.
      in_valid = 1'b1;
      in_data  = 8'h3C;
      tick();
      in_valid = 1'b0;
      #1;
      chk_out("3c_first", 1'b1, 1'b0, 8'h3C, 1'b0);
      tick();
      chk_out("3c_second", 1'b1, 1'b1, 8'h3C, 1'b1);
      tick();
      chk_out("3c_done", 1'b0, 1'b0, 8'h3C, 1'b1);
      chk_cnt("3c_done", 8'd2);

      // Back-to-back stream 12 34 56: six nibbles on six consecutive cycles.
      in_valid = 1'b1;
      in_data  = stream[0];
      tick();
      for (int i = 0; i < 3; i++) begin
         if (i < 2) in_data = stream[i+1];
         else in_valid = 1'b0;
         #1;
         chk_out("b2b_first", 1'b1, 1'b0, stream[i], 1'b0);
         chk_rdy("b2b_first", 1'b0);
         tick();
         chk_out("b2b_second", 1'b1, 1'b1, stream[i], 1'b1);
         chk_rdy("b2b_second", 1'b1);
         tick();
      end
      chk_out("b2b_done", 1'b0, 1'b0, 8'h56, 1'b1);
      chk_cnt("b2b_done", 8'd5);

      // Backpressure in FIRST with F0; a new byte on in_data is ignored.
      in_valid  = 1'b1;
      in_data   = 8'hF0;
      out_ready = 1'b0;
      tick();
      in_data = 8'h77;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk_out("bp_stall", 1'b1, 1'b0, 8'hF0, 1'b0);
         chk_rdy("bp_stall", 1'b0);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      chk_out("bp_first", 1'b1, 1'b0, 8'hF0, 1'b0);
      tick();
      chk_out("bp_second", 1'b1, 1'b1, 8'hF0, 1'b1);
      tick();
      chk_out("bp_done", 1'b0, 1'b0, 8'hF0, 1'b1);
      chk_cnt("bp_done", 8'd6);

      // Stall in SECOND: in_ready follows out_ready low, nothing moves.
      in_valid = 1'b1;
      in_data  = 8'h9B;
      tick();
      in_valid = 1'b0;
      tick();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h11;
      #1;
      chk_rdy("st2", 1'b0);
      tick();
      chk_out("st2_hold", 1'b1, 1'b1, 8'h9B, 1'b1);
      chk_cnt("st2_hold", 8'd6);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      chk_cnt("st2_done", 8'd7);

      // Wrap: 249 more bytes bring the count from 7 back to 0.
      in_valid = 1'b1;
      in_data  = 8'h00;
      tick();
      for (int i = 1; i < 249; i++) begin
         in_data = i[7:0];
         tick();
         tick();
      end
      in_valid = 1'b0;
      tick();
      chk_cnt("wrap_255", 8'd255);
      tick();
      chk_cnt("wrap_0", 8'd0);

      // Reset asserted while in SECOND discards the byte.
      in_valid = 1'b1;
      in_data  = 8'h9A;
      tick();
      in_valid = 1'b0;
      tick();
      chk_out("mid_second", 1'b1, 1'b1, 8'h9A, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk_reset("mid_rst");
      for (int i = 0; i < 3; i++) begin
         in_valid  = 1'($urandom);
         out_ready = 1'($urandom);
         in_data   = 8'($urandom);
         tick();
         chk_reset("mid_rst_rand");
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #2 rst_n = 1'b1;
      tick();
      chk_rdy("mid_rel", 1'b1);
      chk_out("mid_rel", 1'b0, 1'b0, 8'h00, 1'b1);

      // One byte after the mid-byte reset counts from zero.
      in_valid = 1'b1;
      in_data  = 8'h5A;
      tick();
      in_valid = 1'b0;
      #1;
      chk_out("post_first", 1'b1, 1'b0, 8'h5A, 1'b0);
      tick();
      tick();
      chk_cnt("post_done", 8'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
